// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared core types. load_entry_t is one outstanding conveyor load:
//   addr       : byte address of the load
//   bank       : target conveyor (0 normal, 1 interrupt)
//   slot       : target conveyor slot
//   misaligned : address bits [1:0] non-zero; completes with F_ALIGN
// The field widths here must match WORD_WIDTH / CONVEYOR_ADDR_WIDTH of the
// units that store these entries.
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned CORE_WORD_WIDTH = 32;
    localparam int unsigned CORE_SLOT_WIDTH = 4;

    typedef struct packed {
        logic [CORE_WORD_WIDTH-1:0] addr;
        logic                       bank;
        logic [CORE_SLOT_WIDTH-1:0] slot;
        logic                       misaligned;
    } load_entry_t;

endpackage

// File: rtl/faults_pkg.sv
// -----------------------------------------------------------------------------
// faults_pkg
// Shared fault codes that go with data written into a conveyor slot.
//   F_NONE  : clean load
//   F_BUS   : memory returned a bus error
//   F_ALIGN : load address was not word aligned, so no memory access was made
// -----------------------------------------------------------------------------
package faults_pkg;

    localparam int unsigned FAULT_W = 3;

    localparam logic [FAULT_W-1:0] F_NONE  = 3'd0;
    localparam logic [FAULT_W-1:0] F_BUS   = 3'd1;
    localparam logic [FAULT_W-1:0] F_ALIGN = 3'd2;

endpackage

// File: rtl/load_queue.sv
// -----------------------------------------------------------------------------
// load_queue
// Ring storage for outstanding loads with three pointers: tail (write), issue
// (next entry to send to memory) and head (oldest entry, next to complete).
// The pointers only move on the strobes from the owner; all occupancy and
// ordering decisions are made by the owner.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (clears pointers)
//   i_push/i_push_entry : write an entry at tail, tail advances
//   i_pop               : head advances
//   i_issue_adv         : issue pointer advances
//   o_issue_*           : fields of the entry at the issue pointer
//   o_head_*            : fields of the entry at head
// -----------------------------------------------------------------------------
module load_queue
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  load_entry_t                i_push_entry,
    input  logic                       i_pop,
    input  logic                       i_issue_adv,
    output logic [CORE_WORD_WIDTH-1:0] o_issue_addr,
    output logic                       o_issue_misaligned,
    output logic                       o_head_bank,
    output logic [CORE_SLOT_WIDTH-1:0] o_head_slot,
    output logic                       o_head_misaligned
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    load_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_issue;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_issue <= '0;
        end else begin
            if (i_push)      r_tail  <= r_tail + PTR_W'(1);
            if (i_pop)       r_head  <= r_head + PTR_W'(1);
            if (i_issue_adv) r_issue <= r_issue + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_tail] <= i_push_entry;
    end

    always_comb begin
        o_issue_addr       = r_mem[r_issue].addr;
        o_issue_misaligned = r_mem[r_issue].misaligned;
        o_head_bank        = r_mem[r_head].bank;
        o_head_slot        = r_mem[r_head].slot;
        o_head_misaligned  = r_mem[r_head].misaligned;
    end

endmodule

// File: rtl/conveyor_load_unit.sv
// -----------------------------------------------------------------------------
// conveyor_load_unit
// Accepts load requests from decode, reads aligned addresses from memory and
// writes the result (or a fault) into a conveyor slot, strictly in request
// order. Misaligned requests skip memory and complete with F_ALIGN.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_*                 : request handshake (addr, bank, slot)
//   mem_rd_*              : registered memory read request (valid/ready)
//   mem_resp_*            : in-order read data with bus-error flag
//   cv_wr_*               : registered one-cycle conveyor slot write
//   busy                  : at least one entry queued
// -----------------------------------------------------------------------------
module conveyor_load_unit
    import core_pkg::*;
    import faults_pkg::*;
#(
    parameter int unsigned WORD_WIDTH          = CORE_WORD_WIDTH,
    parameter int unsigned CONVEYOR_ADDR_WIDTH = CORE_SLOT_WIDTH,
    parameter int unsigned FAULT_ADDR_WIDTH    = FAULT_W,
    parameter int unsigned QUEUE_DEPTH         = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [WORD_WIDTH-1:0]          req_addr,
    input  logic                           req_bank,
    input  logic [CONVEYOR_ADDR_WIDTH-1:0] req_slot,
    output logic                           mem_rd_valid,
    input  logic                           mem_rd_ready,
    output logic [WORD_WIDTH-1:0]          mem_rd_addr,
    input  logic                           mem_resp_valid,
    input  logic [WORD_WIDTH-1:0]          mem_resp_data,
    input  logic                           mem_resp_err,
    output logic                           cv_wr_valid,
    output logic                           cv_wr_bank,
    output logic [CONVEYOR_ADDR_WIDTH-1:0] cv_wr_slot,
    output logic [WORD_WIDTH-1:0]          cv_wr_data,
    output logic [FAULT_ADDR_WIDTH-1:0]    cv_wr_fault,
    output logic                           busy
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [CNT_W-1:0]               r_count;
    logic [CNT_W-1:0]               r_n_issued;  // entries between head and issue ptr
    logic [CNT_W-1:0]               r_n_mis;     // misaligned entries passed, not completed
    logic                           r_req_ready;
    logic                           r_mem_rd_valid;
    logic [WORD_WIDTH-1:0]          r_mem_rd_addr;
    logic                           r_cv_wr_valid;
    logic                           r_cv_wr_bank;
    logic [CONVEYOR_ADDR_WIDTH-1:0] r_cv_wr_slot;
    logic [WORD_WIDTH-1:0]          r_cv_wr_data;
    logic [FAULT_ADDR_WIDTH-1:0]    r_cv_wr_fault;

    load_entry_t                    w_push_entry;
    logic [WORD_WIDTH-1:0]          w_issue_addr;
    logic                           w_issue_mis;
    logic                           w_head_bank;
    logic [CONVEYOR_ADDR_WIDTH-1:0] w_head_slot;
    logic                           w_head_mis;
    logic                           w_accept;
    logic                           w_issue_adv;
    logic                           w_issue_start;
    logic                           w_adv_mis;
    logic                           w_complete;
    logic [CNT_W-1:0]               w_count_d;

    load_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_load_queue (
        .clk                (clk),
        .reset              (reset),
        .i_push             (w_accept),
        .i_push_entry       (w_push_entry),
        .i_pop              (w_complete),
        .i_issue_adv        (w_issue_adv),
        .o_issue_addr       (w_issue_addr),
        .o_issue_misaligned (w_issue_mis),
        .o_head_bank        (w_head_bank),
        .o_head_slot        (w_head_slot),
        .o_head_misaligned  (w_head_mis)
    );

    always_comb begin
        w_accept     = req_valid && r_req_ready;
        w_push_entry = '{addr: req_addr, bank: req_bank, slot: req_slot,
                         misaligned: |req_addr[1:0]};

        // A new aligned read is held back while a passed misaligned entry is
        // still waiting to complete: every outstanding read then belongs to a
        // contiguous run of aligned entries starting at head, so a response
        // can never arrive while a misaligned entry sits at head.
        w_issue_adv   = 1'b0;
        w_issue_start = 1'b0;
        if (r_mem_rd_valid) begin
            w_issue_adv = mem_rd_ready;
        end else if (r_n_issued < r_count) begin
            if (w_issue_mis)          w_issue_adv   = 1'b1;
            else if (r_n_mis == '0)   w_issue_start = 1'b1;
        end
        w_adv_mis = w_issue_adv && !r_mem_rd_valid;

        // Head completes only once passed by the issue pointer; responses
        // with no such aligned head are dropped.
        w_complete = (r_n_issued != '0) && (w_head_mis || mem_resp_valid);

        w_count_d = r_count + CNT_W'(w_accept) - CNT_W'(w_complete);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= '0;
            r_n_issued     <= '0;
            r_n_mis        <= '0;
            r_req_ready    <= 1'b1;
            r_mem_rd_valid <= 1'b0;
            r_mem_rd_addr  <= '0;
            r_cv_wr_valid  <= 1'b0;
            r_cv_wr_bank   <= 1'b0;
            r_cv_wr_slot   <= '0;
            r_cv_wr_data   <= '0;
            r_cv_wr_fault  <= '0;
        end else begin
            r_count     <= w_count_d;
            r_req_ready <= (w_count_d < CNT_W'(QUEUE_DEPTH));
            r_n_issued  <= r_n_issued + CNT_W'(w_issue_adv) - CNT_W'(w_complete);
            r_n_mis     <= r_n_mis + CNT_W'(w_adv_mis) - CNT_W'(w_complete && w_head_mis);

            if (w_issue_start) begin
                r_mem_rd_valid <= 1'b1;
                r_mem_rd_addr  <= w_issue_addr;
            end else if (r_mem_rd_valid && mem_rd_ready) begin
                r_mem_rd_valid <= 1'b0;
            end

            r_cv_wr_valid <= w_complete;
            if (w_complete) begin
                r_cv_wr_bank <= w_head_bank;
                r_cv_wr_slot <= w_head_slot;
                if (w_head_mis) begin
                    r_cv_wr_data  <= '0;
                    r_cv_wr_fault <= FAULT_ADDR_WIDTH'(F_ALIGN);
                end else begin
                    r_cv_wr_data  <= mem_resp_data;
                    r_cv_wr_fault <= mem_resp_err ? FAULT_ADDR_WIDTH'(F_BUS)
                                                  : FAULT_ADDR_WIDTH'(F_NONE);
                end
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign mem_rd_valid = r_mem_rd_valid;
    assign mem_rd_addr  = r_mem_rd_addr;
    assign cv_wr_valid  = r_cv_wr_valid;
    assign cv_wr_bank   = r_cv_wr_bank;
    assign cv_wr_slot   = r_cv_wr_slot;
    assign cv_wr_data   = r_cv_wr_data;
    assign cv_wr_fault  = r_cv_wr_fault;
    assign busy         = (r_count != '0);

endmodule
